// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer: the fetch FSM state
// encoding, default parameter values and a small address-alignment helper.
// Optional feature macro: PC_ALIGN_CHECK_EN (the helper is only used when it
// is defined).
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          PC_INC_DEF   = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // FAULT is only reachable when the alignment check is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } seq_state_e;

    // A fetch target must be word aligned; any set low bit is a fault.
    function automatic logic addr_misaligned(input logic [1:0] addr_lo);
        return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the two handshakes around the sequencer:
//   imem_req/imem_addr/imem_ack/imem_rdata     : instruction-memory req/ack
//   instr_valid/instr/instr_pc/instr_ready     : valid/ready towards decode
// master = sequencer side, slave = memory/decode side.
// -----------------------------------------------------------------------------
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    logic              instr_valid;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/pc_sequencer_next_pc_select.sv
// -----------------------------------------------------------------------------
// pc_sequencer_next_pc_select
// Combinational next-PC priority select: jump > taken branch > sequential.
// Ports:
//   jump/jump_target, branch_taken/branch_target : redirect requests
//   pc            : current fetch PC
//   target        : winning redirect target (meaningful when redirect_hit=1)
//   redirect_hit  : any redirect requested this cycle
//   seq_pc        : pc + PC_INC, wrapping modulo 2^ADDR_W
// -----------------------------------------------------------------------------
module pc_sequencer_next_pc_select
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PC_INC = PC_INC_DEF
) (
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] target,
    output logic              redirect_hit,
    output logic [ADDR_W-1:0] seq_pc
);

    // Priority select of the redirect source.
    always_comb begin
        target       = pc;
        redirect_hit = 1'b0;
        if (jump) begin
            target       = jump_target;
            redirect_hit = 1'b1;
        end else if (branch_taken) begin
            target       = branch_target;
            redirect_hit = 1'b1;
        end else begin
            target       = pc;
            redirect_hit = 1'b0;
        end
    end

    // Sequential successor; carry out of the top bit is dropped on purpose.
    always_comb begin
        seq_pc = pc + ADDR_W'(PC_INC);
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter and sequences instruction fetch: one outstanding
// imem request at a time, each fetched word is held for decode until taken.
// Redirects (jump > branch) squash wrong-path fetches; a redirect that lands
// while a request is in flight is parked until the ack retires the request.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   bus (pc_sequencer_if.master)     : imem req/ack and decode valid/ready
//   jump/jump_target                 : jump redirect strobe and destination
//   branch_taken/branch_target       : taken-branch strobe and destination
//   pc                               : current fetch PC
//   align_fault (PC_ALIGN_CHECK_EN)  : sticky misaligned-target flag
//   redirect                         : one-cycle pulse after an accepted redirect
// Optional feature macro: PC_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                PC_INC   = PC_INC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_sequencer_if.master        bus,
    input  logic                  jump,
    input  logic [ADDR_W-1:0]     jump_target,
    input  logic                  branch_taken,
    input  logic [ADDR_W-1:0]     branch_target,
    output logic [ADDR_W-1:0]     pc,
`ifdef PC_ALIGN_CHECK_EN
    output logic                  align_fault,
`endif
    output logic                  redirect
);

    seq_state_e        state_r, state_nx_s;
    logic [ADDR_W-1:0] pc_r, pc_nx_s;
    logic              pend_valid_r, pend_valid_nx_s;
    logic [ADDR_W-1:0] pend_target_r, pend_target_nx_s;
    logic [31:0]       instr_r, instr_nx_s;
    logic [ADDR_W-1:0] instr_pc_r, instr_pc_nx_s;
    logic              imem_req_r;
    logic              instr_valid_r;
    logic              redirect_r;
    logic              accept_s;
    logic [ADDR_W-1:0] target_s;
    logic              redirect_hit_s;
    logic [ADDR_W-1:0] seq_pc_s;
`ifdef PC_ALIGN_CHECK_EN
    logic              align_fault_r, fault_nx_s;
`endif

    pc_sequencer_next_pc_select #(
        .ADDR_W (ADDR_W),
        .PC_INC (PC_INC)
    ) u_next_pc_select (
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc_r),
        .target        (target_s),
        .redirect_hit  (redirect_hit_s),
        .seq_pc        (seq_pc_s)
    );

    // Next-state and datapath update decisions for the fetch FSM.
    always_comb begin
        state_nx_s       = state_r;
        pc_nx_s          = pc_r;
        pend_valid_nx_s  = pend_valid_r;
        pend_target_nx_s = pend_target_r;
        instr_nx_s       = instr_r;
        instr_pc_nx_s    = instr_pc_r;
        accept_s         = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        fault_nx_s       = align_fault_r;
`endif
        case (state_r)
            IDLE: begin
                // A late ack from before reset lands here and is ignored.
                state_nx_s = FETCH;
            end
            FETCH: begin
                if (redirect_hit_s) begin
                    accept_s = 1'b1;
                    if (bus.imem_ack) begin
                        // In-flight word is wrong-path: drop it, refetch at target.
                        pc_nx_s         = target_s;
                        pend_valid_nx_s = 1'b0;
                    end else begin
                        // Request is never aborted; park the target (latest wins).
                        pend_valid_nx_s  = 1'b1;
                        pend_target_nx_s = target_s;
                    end
                end else if (pend_valid_r) begin
                    if (bus.imem_ack) begin
                        pc_nx_s         = pend_target_r;
                        pend_valid_nx_s = 1'b0;
                    end else begin
                        pend_valid_nx_s = 1'b1;
                    end
                end else if (bus.imem_ack) begin
                    instr_nx_s    = bus.imem_rdata;
                    instr_pc_nx_s = pc_r;
                    pc_nx_s       = seq_pc_s;
                    state_nx_s    = HOLD;
                end else begin
                    state_nx_s = FETCH;
                end
            end
            HOLD: begin
                // pc already points past the held word, so a redirect simply
                // replaces it whether or not decode takes the word this cycle.
                if (redirect_hit_s) begin
                    accept_s   = 1'b1;
                    pc_nx_s    = target_s;
                    state_nx_s = FETCH;
                end else if (bus.instr_ready) begin
                    state_nx_s = FETCH;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            default: begin
                state_nx_s = state_r;
            end
        endcase
`ifdef PC_ALIGN_CHECK_EN
        if (accept_s && addr_misaligned(target_s[1:0])) begin
            state_nx_s      = FAULT;
            fault_nx_s      = 1'b1;
            pend_valid_nx_s = 1'b0;
            pc_nx_s         = pc_r;
        end else begin
            fault_nx_s = align_fault_r;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // PC, pending redirect, held instruction and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            pend_valid_r  <= 1'b0;
            pend_target_r <= '0;
            instr_r       <= 32'h0000_0000;
            instr_pc_r    <= '0;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            redirect_r    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            align_fault_r <= 1'b0;
`endif
        end else begin
            pc_r          <= pc_nx_s;
            pend_valid_r  <= pend_valid_nx_s;
            pend_target_r <= pend_target_nx_s;
            instr_r       <= instr_nx_s;
            instr_pc_r    <= instr_pc_nx_s;
            imem_req_r    <= (state_nx_s == FETCH);
            instr_valid_r <= (state_nx_s == HOLD);
            redirect_r    <= accept_s;
`ifdef PC_ALIGN_CHECK_EN
            align_fault_r <= fault_nx_s;
`endif
        end
    end

    assign bus.imem_req    = imem_req_r;
    assign bus.imem_addr   = pc_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.instr       = instr_r;
    assign bus.instr_pc    = instr_pc_r;
    assign pc              = pc_r;
    assign redirect        = redirect_r;
`ifdef PC_ALIGN_CHECK_EN
    assign align_fault     = align_fault_r;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter and sequences instruction fetch over a req/ack instruction-memory handshake. Merges redirects from execute (jump, taken branch) with the same priority as the PC-final select: jump > branch > sequential. Delivers fetched instructions to decode over a valid/ready handshake and squashes wrong-path fetches. Sits between instruction memory and decode, replacing the free-running PC register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address
PC_INC, 4, sequential increment in bytes
ADDR_W, 32, PC / target / memory address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request; held until imem_ack
imem_addr  output  ADDR_W  fetch address; stable while imem_req=1
imem_ack  input  1  one-cycle completion strobe; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  instruction offered to decode
instr  output  32  held instruction word
instr_pc  output  ADDR_W  address of held instruction
instr_ready  input  1  decode accepts (transfer when valid & ready)
jump  input  1  jump redirect strobe (one cycle)
jump_target  input  ADDR_W  jump destination
branch_taken  input  1  taken-branch redirect strobe (one cycle)
branch_target  input  ADDR_W  branch destination
pc  output  ADDR_W  current fetch PC
redirect  output  1  registered; pulses one cycle after any accepted redirect (flush indication)

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, redirect=0, pending redirect cleared. Mid-operation reset abandons any outstanding fetch; a late imem_ack after reset is ignored while state is IDLE.
- States: IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack with no pending/current redirect: capture instr=imem_rdata, instr_pc=pc, pc<=pc+PC_INC (mod 2^ADDR_W, wraps silently), go HOLD.
- HOLD: instr_valid=1, imem_req=0. On instr_ready: instr_valid drops next cycle, go FETCH. Fetch-to-valid latency = 1 cycle after imem_ack.
- Redirect target select: jump ? jump_target : branch_taken ? branch_target : none. Both asserted -> jump wins.
- Redirect in FETCH before ack: record pending target; request stays asserted at the old address until ack (no request abort). On ack: discard imem_rdata, pc<=target, stay FETCH (new request next cycle).
- Redirect same cycle as imem_ack: data discarded, pc<=target, stay FETCH.
- Redirect in HOLD without instr_ready: held instruction dropped (instr_valid=0 next cycle), pc<=target, go FETCH.
- Redirect in HOLD with instr_ready same cycle: transfer completes; next fetch uses target.
- A second redirect while one is pending overwrites it (latest wins).
- redirect output = 1 the cycle after any accepted redirect strobe.

Optional Feature:
PC_ALIGN_CHECK_EN: when defined, adds output align_fault (1 bit, reset 0). A redirect target with bits [1:0] != 0 sets align_fault sticky and sends FSM to FAULT: imem_req=0, instr_valid=0, no further transitions until reset. When undefined: no port, no FAULT state; targets used verbatim.

Decomposition:
- Shared package: state enum {IDLE, FETCH, HOLD, FAULT}, PC_INC and RESET_PC defaults, ADDR_W.
- One sub-module natural: next_pc_select (combinational jump > branch > sequential priority select, producing target and redirect_hit); FSM and registers stay in pc_sequencer.

Test Plan:
- Reset release, ack 2 cycles after each req, instr_ready=1 -> fetch addrs 0x0,0x4,0x8; instr_pc matches; instr_valid 1 cycle after each ack.
- instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, no pc advance.
- jump=1 target 0x100 while req to 0x8 outstanding, ack 3 cycles later -> data for 0x8 never valid; next imem_addr=0x100; redirect pulses once.
- jump=1 (0x200) and branch_taken=1 (0x300) same cycle -> next fetch 0x200.
- branch_taken target 0x40 in HOLD with instr_ready=1 -> held instruction transfers; next imem_addr=0x40.
- rst_n low mid-FETCH then ack arrives -> ignored; fetch restarts at RESET_PC; with PC_ALIGN_CHECK_EN, jump_target 0x102 -> align_fault=1, imem_req stays 0.
